// File: rtl/motor_pwm_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : motor_pwm_gen_if
//  Description : Control/status bundle between the upstream speed FSM and the
//                motor PWM generator. Signal names follow the generator's
//                point of view (i_ = into the generator, o_ = out of it).
//  Revision    : 1.0  initial release
// ============================================================================
interface motor_pwm_gen_if;
    logic       i_enable;
    logic [2:0] i_pwm_state;
    logic       o_pwm;
    logic       o_period_start;
    logic [2:0] o_level;
    logic       o_ramping;

    // Upstream side: commands the generator and observes its status.
    modport master (
        output i_enable,
        output i_pwm_state,
        input  o_pwm,
        input  o_period_start,
        input  o_level,
        input  o_ramping
    );

    // Generator side.
    modport slave (
        input  i_enable,
        input  i_pwm_state,
        output o_pwm,
        output o_period_start,
        output o_level,
        output o_ramping
    );
endinterface
`default_nettype wire

// File: rtl/motor_pwm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : motor_pwm_gen
//  Description : Converts a 0..4 speed level into a fixed-frequency PWM drive
//                (0/25/50/75/100 % duty). Level changes are applied only at
//                period boundaries, optionally ramping one step per period.
//  Revision    : 1.0  initial release
// ============================================================================
module motor_pwm_gen #(
    parameter int CLK_DIV          = 1000, // system clocks per PWM tick, >= 1
    parameter int TICKS_PER_PERIOD = 100,  // ticks per period, multiple of 4, >= 4
    parameter int RAMP_EN          = 1     // 1 = step one level per period
) (
    input  wire logic          i_clk,
    input  wire logic          i_reset,
    motor_pwm_gen_if.slave     s_if
);

    // A width of at least 1 keeps the prescaler legal when CLK_DIV is 1.
    localparam int c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_CNT_W   = $clog2(TICKS_PER_PERIOD);
    // One extra bit so the threshold can hold TICKS_PER_PERIOD itself (level 4).
    localparam int c_THR_W   = c_CNT_W + 1;
    localparam int c_QUARTER = TICKS_PER_PERIOD / 4;

    localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TICKS_PER_PERIOD - 1);
    localparam logic [c_THR_W-1:0] c_QTR     = c_THR_W'(c_QUARTER);
    localparam logic [2:0]         c_LVL_MAX = 3'd4;

    logic [c_DIV_W-1:0] r_div;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_level;
    logic               r_pwm;
    logic               r_period_start;
    logic               r_ramping;
    // Set while held in reset or disabled; the first enabled clock afterwards
    // opens a fresh period (count 0, period-start pulse) without advancing.
    logic               r_idle;

    logic [2:0]         w_target;
    logic               w_tick;
    logic               w_bound;
    logic [2:0]         w_next_level;
    logic [c_THR_W-1:0] w_thr;

    // Illegal speed codes 5..7 are treated as "off".
    assign w_target = (s_if.i_pwm_state <= c_LVL_MAX) ? s_if.i_pwm_state : 3'd0;
    assign w_tick   = (r_div == c_DIV_MAX);
    assign w_bound  = w_tick && (r_cnt == c_CNT_MAX);
    assign w_thr    = c_THR_W'(r_level) * c_QTR;

    // Level to apply at the next boundary: jump, or one step toward target.
    always_comb begin
        w_next_level = r_level;
        if (RAMP_EN == 0) begin
            w_next_level = w_target;
        end else if (w_target > r_level) begin
            w_next_level = r_level + 3'd1;
        end else if (w_target < r_level) begin
            w_next_level = r_level - 3'd1;
        end
    end

    // Prescaler, period counter, applied level and all registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_div          <= '0;
            r_cnt          <= '0;
            r_level        <= '0;
            r_pwm          <= 1'b0;
            r_period_start <= 1'b0;
            r_ramping      <= 1'b0;
            r_idle         <= 1'b1;
        end else begin
            r_ramping <= (r_level != w_target);
            // Compare against the current count: one clock of latency, so a
            // level-4 threshold of TICKS_PER_PERIOD never drops across a wrap.
            r_pwm     <= s_if.i_enable && ({1'b0, r_cnt} < w_thr);
            if (!s_if.i_enable) begin
                r_div          <= '0;
                r_cnt          <= '0;
                r_level        <= '0;
                r_period_start <= 1'b0;
                r_idle         <= 1'b1;
            end else if (r_idle) begin
                r_div          <= '0;
                r_cnt          <= '0;
                r_period_start <= 1'b1;
                r_idle         <= 1'b0;
            end else begin
                r_period_start <= w_bound;
                if (w_tick) begin
                    r_div <= '0;
                    r_cnt <= (r_cnt == c_CNT_MAX) ? '0 : r_cnt + c_CNT_W'(1);
                end else begin
                    r_div <= r_div + c_DIV_W'(1);
                end
                // Only the request present on the boundary clock is honoured.
                if (w_bound) begin
                    r_level <= w_next_level;
                end
            end
        end
    end

    assign s_if.o_pwm          = r_pwm;
    assign s_if.o_period_start = r_period_start;
    assign s_if.o_level        = r_level;
    assign s_if.o_ramping      = r_ramping;

endmodule
`default_nettype wire

// File: doc/motor_pwm_gen.md
Name: motor_pwm_gen

Overview:
- Downstream stage of the motor speed FSM. Consumes its 3-bit speed level (0..4) and drives the motor's PWM pin.
- Converts the level into a fixed-frequency PWM waveform with duty of 0/25/50/75/100 %.
- Duty changes take effect only at period boundaries, so no runt pulses occur. An optional soft-ramp moves at most one level per period.

Parameters:
- CLK_DIV, 1000: system clocks per PWM tick; must be ≥1.
- TICKS_PER_PERIOD, 100: ticks per PWM period; must be a multiple of 4 and ≥4.
- RAMP_EN, 1: 1 = applied level steps by ±1 per period toward target; 0 = jumps directly to target.

Ports:
- i_clk  input  1  system clock, all logic on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_enable  input  1  1 = generator runs; 0 = output forced off.
- i_pwm_state  input  3  requested speed level from upstream FSM (0..4; 5..7 illegal).
- o_pwm  output  1  registered PWM drive to motor driver.
- o_period_start  output  1  one-clock pulse at the start of each PWM period.
- o_level  output  3  level currently applied to the waveform.
- o_ramping  output  1  high while o_level ≠ target level.

Behaviour:
- Reset (i_reset=1 at a rising edge) clears all state, taking precedence over everything else:
  - prescaler, tick counter, o_level, o_pwm, o_period_start and o_ramping all go to 0.
  - Reset mid-period abandons the period. The next period starts from count 0 after reset deasserts.
- Target level = i_pwm_state if ≤4, else 0 (illegal codes map to off).
- Prescaler r_div counts 0..CLK_DIV-1 and wraps.
  - tick = (r_div == CLK_DIV-1).
  - With CLK_DIV=1, tick is asserted every clock.
- Tick counter r_cnt advances only on tick, counting 0..TICKS_PER_PERIOD-1 and wrapping.
- Period boundary = tick AND r_cnt == TICKS_PER_PERIOD-1.
- At a period boundary, on the same edge that wraps r_cnt to 0:
  - i_pwm_state is sampled. Changes between boundaries are ignored; only the value present at the boundary clock counts.
  - RAMP_EN=0: o_level <= target.
  - RAMP_EN=1: o_level <= o_level+1 if target > o_level; o_level-1 if target < o_level; otherwise unchanged.
- o_period_start is registered. It is 1 for exactly one clock: the clock in which r_cnt first shows 0 after a wrap. It also pulses on the first period after reset release or enable.
- Threshold thr = o_level × (TICKS_PER_PERIOD/4). Arithmetic is unsigned, wide enough for TICKS_PER_PERIOD.
- o_pwm is a registered output: each clock, o_pwm <= i_enable AND (r_cnt < thr). This gives a fixed one-clock latency from r_cnt.
  - Level 0: o_pwm never high.
  - Level 4: o_pwm continuously high, with no low clock across period wraps.
- o_ramping is registered, equal to (o_level ≠ target) evaluated each clock using the current input.
- i_enable=0 (synchronous):
  - r_div, r_cnt and o_level are forced to 0.
  - o_pwm goes to 0 on the next clock; o_period_start stays 0.
- Re-enable: counting restarts from 0. With RAMP_EN=1, the level ramps up from 0 starting at the first boundary.
- Simultaneous boundary and i_enable falling: disable wins and the level goes to 0.
- Duty in clocks = thr × CLK_DIV per period of TICKS_PER_PERIOD × CLK_DIV clocks.

Test Plan:
- Bench config: CLK_DIV=2, TICKS_PER_PERIOD=8 (16-clock period, 2 ticks per level step).
1. Reset / idle: assert i_reset 3 clocks with i_pwm_state=3, RAMP_EN=0 → o_pwm=0, o_level=0, o_period_start=0. After release, the first o_period_start pulse is followed, one period later, by o_level=3 and o_pwm high 12 of every 16 clocks.
2. Duty sweep, RAMP_EN=0: hold i_pwm_state=0,1,2,3,4 for 3 periods each → steady-state high time per 16-clock period is 0, 4, 8, 12, 16 clocks. Level 4 shows o_pwm constantly 1.
3. Ramp, RAMP_EN=1: step i_pwm_state 0→4 → o_level reads 1,2,3,4 on four successive boundaries, o_ramping=1 until o_level=4. Then step 4→0 → o_level reads 3,2,1,0.
4. Mid-period change: switch i_pwm_state 1→3 at r_cnt=2 and back to 1 at r_cnt=5 → o_level stays 1 and the waveform is unchanged (no glitch). A change held through the boundary is applied.
5. Illegal input: i_pwm_state=6 at a boundary → target 0, o_pwm stays low for the following period.
6. Enable/reset mid-period:
   - Drop i_enable at r_cnt=3 with level 2 → o_pwm=0 on the next clock, o_level=0. Re-enable → o_period_start is seen 1 clock later and counting restarts from 0.
   - Same sequence with i_reset in place of i_enable → identical result.
